// File: rtl/pipe_fwd_tracker_if.sv
// Bundle of issue, operand, result and forwarding signals between the decode
// stage / datapath and the forwarding tracker.
interface pipe_fwd_tracker_if #(
    parameter int NSTAGES = 3,
    parameter int NSRC    = 2,
    parameter int XLEN    = 64,
    parameter int RADDR   = 5,
    parameter int SELW    = $clog2(NSTAGES + 1)
);
    logic                    hold;
    logic [NSTAGES-1:0]      flush_mask;
    logic                    issue_valid;
    logic                    issue_wen;
    logic [RADDR-1:0]        issue_dst;
    logic                    issue_late;
    logic [SELW-1:0]         issue_lat;
    logic [NSRC*RADDR-1:0]   src_ra;
    logic [NSRC-1:0]         src_used;
    logic [NSTAGES*XLEN-1:0] stage_wd;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [NSRC*XLEN-1:0]    fwd_data;
    logic                    stall;
    logic [31:0]             stall_cnt;

    // Decode stage and datapath side
    modport master (
        output hold, flush_mask, issue_valid, issue_wen, issue_dst,
               issue_late, issue_lat, src_ra, src_used, stage_wd,
        input  fwd_sel, fwd_data, stall, stall_cnt
    );

    // Tracker side
    modport slave (
        input  hold, flush_mask, issue_valid, issue_wen, issue_dst,
               issue_late, issue_lat, src_ra, src_used, stage_wd,
        output fwd_sel, fwd_data, stall, stall_cnt
    );
endinterface

// File: rtl/pipe_fwd_tracker.sv
// Forwarding / hazard tracker beside decode. Keeps a shift pipeline of
// in-flight register writes for NSTAGES post-decode stages, resolves the
// forwarding source for each decode operand and stalls decode when the
// youngest producer of an operand has not yet produced its result.
module pipe_fwd_tracker #(
    parameter int NSTAGES = 3,
    parameter int NSRC    = 2,
    parameter int XLEN    = 64,
    parameter int RADDR   = 5,
    parameter int SELW    = $clog2(NSTAGES + 1)
) (
    input logic               clk,
    input logic               reset,
    pipe_fwd_tracker_if.slave bus
);

    // Saturating increment for the stall counter
    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (&x) ? x : x + 32'd1;
    endfunction

    // Per-stage tracked write: valid, writes-register, destination, first
    // stage index at which the result is available.
    logic [NSTAGES-1:0] stg_v;
    logic [NSTAGES-1:0] stg_wen;
    logic [RADDR-1:0]   stg_dst [NSTAGES];
    logic [SELW-1:0]    stg_lat [NSTAGES];
    logic [31:0]        stall_cnt_q;

    logic [NSRC*SELW-1:0] sel_c;
    logic [NSRC*XLEN-1:0] data_c;
    logic [NSRC-1:0]      nrdy_c;
    logic                 stall_c;

    // Operand lookup: scan oldest to youngest so the youngest match overwrites
    always_comb begin
        sel_c  = '0;
        data_c = '0;
        nrdy_c = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (bus.src_used[s] && (bus.src_ra[s*RADDR +: RADDR] != '0)) begin
                for (int k = NSTAGES - 1; k >= 0; k--) begin
                    if (stg_v[k] && stg_wen[k] &&
                        (stg_dst[k] == bus.src_ra[s*RADDR +: RADDR])) begin
                        if (k >= int'(stg_lat[k])) begin
                            sel_c[s*SELW +: SELW]  = SELW'(k + 1);
                            data_c[s*XLEN +: XLEN] = bus.stage_wd[k*XLEN +: XLEN];
                            nrdy_c[s]              = 1'b0;
                        end else begin
                            sel_c[s*SELW +: SELW]  = '0;
                            data_c[s*XLEN +: XLEN] = '0;
                            nrdy_c[s]              = 1'b1;
                        end
                    end
                end
            end
        end
        stall_c = bus.issue_valid & (|nrdy_c);
    end

    assign bus.fwd_sel   = sel_c;
    assign bus.fwd_data  = data_c;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;

    // Stage shift with flush and hold; flush still lands while held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v       <= '0;
            stg_wen     <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                stg_dst[k] <= '0;
                stg_lat[k] <= '0;
            end
        end else if (bus.hold) begin
            for (int k = 0; k < NSTAGES; k++) begin
                if (bus.flush_mask[k]) begin
                    stg_v[k] <= 1'b0;
                end
            end
        end else begin
            stg_v[0]   <= bus.issue_valid & ~stall_c & ~bus.flush_mask[0];
            stg_wen[0] <= bus.issue_wen;
            stg_dst[0] <= bus.issue_dst;
            stg_lat[0] <= bus.issue_late ? bus.issue_lat : '0;
            for (int k = 1; k < NSTAGES; k++) begin
                stg_v[k]   <= stg_v[k-1] & ~bus.flush_mask[k];
                stg_wen[k] <= stg_wen[k-1];
                stg_dst[k] <= stg_dst[k-1];
                stg_lat[k] <= stg_lat[k-1];
            end
            if (stall_c) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

endmodule

// File: tb/tb_pipe_fwd_tracker.sv
// Directed bench for pipe_fwd_tracker with a scoreboard of expected outputs.
module tb_pipe_fwd_tracker;
    localparam int NSTAGES = 3;
    localparam int NSRC    = 2;
    localparam int XLEN    = 64;
    localparam int RADDR   = 5;
    localparam int SELW    = $clog2(NSTAGES + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_fwd_tracker_if #(.NSTAGES(NSTAGES), .NSRC(NSRC), .XLEN(XLEN),
                          .RADDR(RADDR), .SELW(SELW)) bus ();

    pipe_fwd_tracker #(.NSTAGES(NSTAGES), .NSRC(NSRC), .XLEN(XLEN),
                       .RADDR(RADDR), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [63:0] obs);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%0h expected=entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [63:0] sel64(input int s);
        return 64'(bus.fwd_sel[s*SELW +: SELW]);
    endfunction

    function automatic logic [63:0] data64(input int s);
        return 64'(bus.fwd_data[s*XLEN +: XLEN]);
    endfunction

    task automatic expect_src(input string tag, input logic [63:0] sel,
                              input logic [63:0] data, input logic stall);
        push({tag, "_sel"}, sel);
        push({tag, "_data"}, data);
        push({tag, "_stall"}, 64'(stall));
    endtask

    task automatic observe_src(input int s);
        pop_cmp(sel64(s));
        pop_cmp(data64(s));
        pop_cmp(64'(bus.stall));
    endtask

    task automatic idle();
        bus.hold        = 1'b0;
        bus.flush_mask  = '0;
        bus.issue_valid = 1'b0;
        bus.issue_wen   = 1'b0;
        bus.issue_dst   = '0;
        bus.issue_late  = 1'b0;
        bus.issue_lat   = '0;
        bus.src_ra      = '0;
        bus.src_used    = '0;
    endtask

    task automatic issue(input logic [RADDR-1:0] dst, input logic late,
                         input logic [SELW-1:0] lat);
        bus.issue_valid = 1'b1;
        bus.issue_wen   = 1'b1;
        bus.issue_dst   = dst;
        bus.issue_late  = late;
        bus.issue_lat   = lat;
    endtask

    task automatic src(input int s, input logic [RADDR-1:0] ra, input logic used);
        bus.src_ra[s*RADDR +: RADDR] = ra;
        bus.src_used[s]              = used;
    endtask

    task automatic wd(input int k, input logic [XLEN-1:0] v);
        bus.stage_wd[k*XLEN +: XLEN] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        idle();
        bus.stage_wd = '0;
        reset = 1'b1;
        tick();
        expect_src("reset", 0, 0, 1'b0);
        push("reset_cnt", 0);
        #1;
        observe_src(0);
        pop_cmp(64'(bus.stall_cnt));
        reset = 1'b0;

        // back-to-back ALU dependency
        issue(5, 1'b0, 0);
        tick();
        idle();
        src(0, 5, 1'b1);
        wd(0, 64'h1234);
        expect_src("b2b", 1, 64'h1234, 1'b0);
        push("b2b_sel1", 0);
        #1;
        observe_src(0);
        pop_cmp(sel64(1));
        drain();

        // load-use: one stall, then forward from stage 1
        issue(7, 1'b1, 1);
        tick();
        issue(8, 1'b0, 0);
        src(0, 7, 1'b1);
        wd(1, 64'hBEEF);
        expect_src("lu_stall", 0, 0, 1'b1);
        #1;
        observe_src(0);
        tick();
        expect_src("lu_fwd", 2, 64'hBEEF, 1'b0);
        push("lu_cnt", 1);
        #1;
        observe_src(0);
        pop_cmp(64'(bus.stall_cnt));
        drain();

        // youngest producer wins
        issue(3, 1'b0, 0);
        tick();
        idle();
        tick();
        issue(3, 1'b0, 0);
        tick();
        idle();
        src(0, 3, 1'b1);
        src(1, 3, 1'b1);
        wd(0, 64'h5555);
        wd(1, 64'h7777);
        wd(2, 64'hAAAA);
        expect_src("young0", 1, 64'h5555, 1'b0);
        expect_src("young1", 1, 64'h5555, 1'b0);
        #1;
        observe_src(0);
        observe_src(1);
        tick();
        expect_src("young_s1", 2, 64'h7777, 1'b0);
        #1;
        observe_src(0);
        drain();

        // x0 never forwarded, unused source never stalls, lat=2 producer
        issue(0, 1'b0, 0);
        tick();
        issue(10, 1'b1, 2);
        tick();
        issue(11, 1'b0, 0);
        src(0, 0, 1'b1);
        src(1, 10, 1'b0);
        wd(2, 64'hCAFE);
        expect_src("x0", 0, 0, 1'b0);
        expect_src("unused", 0, 0, 1'b0);
        #1;
        observe_src(0);
        observe_src(1);
        src(1, 10, 1'b1);
        expect_src("late_a", 0, 0, 1'b1);
        #1;
        observe_src(1);
        tick();
        expect_src("late_b", 0, 0, 1'b1);
        #1;
        observe_src(1);
        tick();
        expect_src("late_c", 3, 64'hCAFE, 1'b0);
        push("late_cnt", 3);
        #1;
        observe_src(1);
        pop_cmp(64'(bus.stall_cnt));
        drain();

        // flush stage 0 kills the incoming issue
        issue(9, 1'b0, 0);
        bus.flush_mask = 3'b001;
        tick();
        idle();
        issue(13, 1'b0, 0);
        src(0, 9, 1'b1);
        expect_src("flush0", 0, 0, 1'b0);
        #1;
        observe_src(0);
        drain();

        // flush stage 1 kills the entry shifting into it
        issue(9, 1'b0, 0);
        tick();
        idle();
        bus.flush_mask = 3'b010;
        tick();
        idle();
        src(0, 9, 1'b1);
        expect_src("flush1", 0, 0, 1'b0);
        #1;
        observe_src(0);
        drain();

        // hold freezes stages and counter; flush still applies
        issue(12, 1'b1, 2);
        tick();
        idle();
        issue(14, 1'b0, 0);
        src(0, 12, 1'b1);
        bus.hold = 1'b1;
        repeat (4) tick();
        expect_src("hold", 0, 0, 1'b1);
        push("hold_cnt", 3);
        #1;
        observe_src(0);
        pop_cmp(64'(bus.stall_cnt));
        bus.flush_mask = 3'b001;
        tick();
        bus.flush_mask = 3'b000;
        expect_src("hold_flush", 0, 0, 1'b0);
        push("hold_flush_cnt", 3);
        #1;
        observe_src(0);
        pop_cmp(64'(bus.stall_cnt));
        drain();

        // asynchronous reset mid-stream
        issue(5, 1'b0, 0);
        tick();
        issue(6, 1'b1, 2);
        tick();
        idle();
        bus.issue_valid = 1'b1;
        src(0, 5, 1'b1);
        src(1, 6, 1'b1);
        wd(1, 64'h5151);
        expect_src("pre_rst", 2, 64'h5151, 1'b1);
        #1;
        observe_src(0);
        #1;
        reset = 1'b1;
        expect_src("rst0", 0, 0, 1'b0);
        expect_src("rst1", 0, 0, 1'b0);
        push("rst_cnt", 0);
        #1;
        observe_src(0);
        observe_src(1);
        pop_cmp(64'(bus.stall_cnt));
        reset = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_fwd_tracker.md
Name: pipe_fwd_tracker

Overview:
- Parametrised successor to the fixed E/M forwarding selects of the 5-stage core.
- Tracks in-flight register writes across NSTAGES post-decode stages in an internal shift pipeline.
- Resolves forwarding for NSRC source operands of the instruction in decode, and raises a stall when a needed value is not yet produced (load-use or any late producer).
- Sits beside the decode stage; the datapath supplies per-stage result values.

Parameters:
- NSTAGES, 3, number of tracked stages after decode; stage 0 is execute, NSTAGES-1 is writeback.
- NSRC, 2, source operands resolved per cycle.
- XLEN, 64, data width.
- RADDR, 5, register address width; register 0 is never forwarded.
- SELW, $clog2(NSTAGES+1), width of each forward select.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- hold, in, 1, freeze the whole tracker (memory wait).
- flush_mask, in, NSTAGES, bit k: invalidate stage k at the next edge.
- issue_valid, in, 1, decode presents an instruction.
- issue_wen, in, 1, instruction writes a register.
- issue_dst, in, RADDR, destination register.
- issue_late, in, 1, result produced only from stage issue_lat onward (load).
- issue_lat, in, SELW, first stage index whose stage_wd is valid for this instruction.
- src_ra, in, NSRC*RADDR, decode source addresses.
- src_used, in, NSRC, source actually read.
- stage_wd, in, NSTAGES*XLEN, result value currently held by stage k.
- fwd_sel, out, NSRC*SELW, 0 = register file, k+1 = forward from stage k.
- fwd_data, out, NSRC*XLEN, selected forwarded value (0 when sel = 0).
- stall, out, 1, decode must hold; a bubble is inserted into stage 0.
- stall_cnt, out, 32, count of stalled cycles since reset.

Behaviour:
- Per-stage state: v, wen, dst, lat. All cleared on reset (async); stall_cnt = 0.
- Lookup (combinational, per source s with src_used[s] and ra != 0):
  - Search stages 0..NSTAGES-1 for v & wen & dst == ra.
  - The youngest (lowest index) match wins.
  - If the match's stage index >= lat: fwd_sel = index+1 and fwd_data = stage_wd[index].
  - Otherwise the source is not ready: fwd_sel = 0, and the source raises stall.
  - No match: fwd_sel = 0.
- stall = issue_valid & OR of not-ready sources. stall is independent of hold.
- Edge update, priority order:
  - reset.
  - hold = 1: all stage state and stall_cnt frozen. flush_mask is still applied; flush beats hold.
  - Otherwise stage k+1 <= stage k, and stage 0 <= {issue_valid & ~stall, issue_wen, issue_dst, issue_late ? issue_lat : 0}.
  - The last stage shifts out (retired to the register file).
- flush_mask: stage k whose bit is set gets v = 0 after the edge. This applies to the value that would land in k, so flushing stage 0 kills the incoming issue. Flush and shift happen in the same edge.
- stall_cnt increments when stall & ~hold, and saturates at all-ones.
- A stage with wen = 1 and dst = 0 is tracked but never matched.
- Reset mid-operation drops all in-flight entries; outputs go to 0 in the same cycle (async).
- Latency: forwarding and stall are combinational from src_ra and current state; state updates one cycle after issue.

Test Plan:
- Back-to-back ALU dependency: issue wen dst=5, lat=0; next cycle src_ra[0]=5 with stage_wd[0]=0x1234 -> fwd_sel[0]=1, fwd_data[0]=0x1234, stall=0.
- Load-use: issue late dst=7, lat=1; next cycle src 7 -> stall=1 for one cycle (bubble enters stage 0). Following cycle fwd_sel=2 with stage_wd[1] value; stall_cnt=1.
- Youngest wins: dst=3 in stages 2 and 0 with different stage_wd -> fwd_sel=1, stage 0 data.
- x0 and unused sources: src_ra=0 with a matching dst=0 entry, or src_used=0 with a hazard -> fwd_sel=0, stall=0.
- Flush: branch mispredict with flush_mask=3'b001 while issuing dst=9 -> stage 0 invalid next cycle; a later read of 9 gives fwd_sel=0.
- Hold and reset: hold=1 for 4 cycles -> stage contents and stall_cnt unchanged. Assert reset mid-stream -> all fwd_sel=0, stall=0, stall_cnt=0 immediately.
